// File: rtl/instruction_loader.sv
// Writable 16x8 instruction store loaded over a valid/ready byte stream.
// Sessions are length-framed and checksum-verified; the core is held while loading or after a failed load.
module instruction_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_instr,
    output logic              core_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic [ADDR_W:0]   count_next;
    logic [DATA_W-1:0] sum_next;

    // Power-on program image, restored on every reset.
    function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
        case (a)
            4'd0:    default_word = 8'hAB;
            4'd1:    default_word = 8'hDE;
            4'd2:    default_word = 8'h3C;
            4'd3:    default_word = 8'hD6;
            4'd4:    default_word = 8'hBC;
            4'd5:    default_word = 8'hCD;
            4'd6:    default_word = 8'hAE;
            4'd7:    default_word = 8'hA1;
            4'd8:    default_word = 8'hB2;
            4'd9:    default_word = 8'hD4;
            4'd10:   default_word = 8'hE5;
            4'd11:   default_word = 8'hF6;
            4'd12:   default_word = 8'hAF;
            4'd13:   default_word = 8'hEF;
            4'd14:   default_word = 8'h67;
            default: default_word = 8'h88;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        add_wrap = a + b;
    endfunction

    assign byte_ready = (state == S_LEN) || (state == S_LOAD) || (state == S_CHECK);
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state != S_IDLE);
    assign load_done  = (state == S_DONE);
    assign core_hold  = busy || load_err;
    assign core_instr = mem[core_addr];
    assign count_next = load_count + 1'b1;
    assign sum_next   = add_wrap(checksum, byte_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            wr_ptr     <= '0;
            load_count <= '0;
            checksum   <= '0;
            load_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word(i[ADDR_W-1:0]);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_req) begin
                        state      <= S_LEN;
                        load_err   <= 1'b0;
                        load_count <= '0;
                        checksum   <= '0;
                        wr_ptr     <= '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        // Length byte encodes N-1 in its low nibble so N spans 1..16.
                        len   <= {1'b0, byte_data[ADDR_W-1:0]} + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        mem[wr_ptr] <= byte_data;
                        wr_ptr      <= wr_ptr + 1'b1;
                        load_count  <= count_next;
                        checksum    <= sum_next;
                        if (count_next == len) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (sum_next != '0) begin
                            load_err <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
